// File: rtl/accum_requant_pkg.sv
// accum_requant_pkg: shared widths, rounding constant and saturation helpers for the requant stage
package accum_requant_pkg;

    localparam int DEF_DATA_WIDTH = 32;
    localparam int DEF_OUT_WIDTH  = 8;
    localparam int DEF_N_CHANNEL  = 32;
    localparam int DEF_FIFO_DEPTH = 4;
    localparam int CH_W           = $clog2(DEF_N_CHANNEL);
    localparam int SHIFT_W        = 5;

    function automatic logic [63:0] round_term(input logic [SHIFT_W-1:0] sh);
        return (sh == '0) ? 64'd0 : 64'd1 << (sh - 1'b1);
    endfunction

    function automatic logic signed [63:0] saturate(input logic signed [63:0] x, input int ow);
        logic signed [63:0] hi;
        logic signed [63:0] lo;
        hi = (64'sd1 <<< (ow - 1)) - 64'sd1;
        lo = -hi - 64'sd1;
        return (x > hi) ? hi : (x < lo) ? lo : x;
    endfunction

endpackage

// File: rtl/sync_fifo.sv
// sync_fifo: synchronous FIFO that accepts a write while full if a read frees the slot in the same cycle
module sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_wr,
    input  logic [WIDTH-1:0] i_wdata,
    input  logic             i_rd,
    output logic [WIDTH-1:0] o_rdata,
    output logic             o_full,
    output logic             o_empty
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW:0]      wptr;
    logic [AW:0]      rptr;
    logic             wr_en;
    logic             rd_en;

    assign o_empty = wptr == rptr;
    assign o_full  = (wptr[AW] != rptr[AW]) && (wptr[AW-1:0] == rptr[AW-1:0]);
    assign wr_en   = i_wr && (!o_full || i_rd);
    assign rd_en   = i_rd && !o_empty;
    assign o_rdata = mem[rptr[AW-1:0]];

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            wptr <= '0;
            rptr <= '0;
        end else begin
            if (wr_en) wptr <= wptr + 1'b1;
            if (rd_en) rptr <= rptr + 1'b1;
        end
    end

    always_ff @(posedge i_clk) begin
        if (wr_en) mem[wptr[AW-1:0]] <= i_wdata;
    end

endmodule

// File: rtl/accum_requant.sv
// accum_requant: bias add, round-half-up shift, optional ReLU and saturation into a valid/ready output FIFO
module accum_requant
    import accum_requant_pkg::*;
#(
    parameter int DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int OUT_WIDTH  = DEF_OUT_WIDTH,
    parameter int N_CHANNEL  = 1 << CH_W,
    parameter int FIFO_DEPTH = DEF_FIFO_DEPTH
) (
    input  logic                         i_clk,
    input  logic                         i_rst,
    input  logic [DATA_WIDTH-1:0]        i_accum_data,
    input  logic                         i_accum_valid,
    input  logic [DATA_WIDTH-1:0]        i_param_cfg_bias,
    input  logic [SHIFT_W-1:0]           i_param_cfg_shift,
    input  logic                         i_relu_en,
    output logic [OUT_WIDTH-1:0]         o_data,
    output logic                         o_valid,
    input  logic                         i_ready,
    output logic [$clog2(N_CHANNEL)-1:0] o_out_ch,
    output logic                         o_last,
    output logic                         o_overflow
);

    localparam int CW = $clog2(N_CHANNEL);
    localparam int W2 = DATA_WIDTH + 2;

    logic                  v1;
    logic                  relu1;
    logic [DATA_WIDTH:0]   sum1;
    logic [SHIFT_W-1:0]    sh1;
    logic signed [W2-1:0]  rnd;
    logic signed [W2-1:0]  s2;
    logic signed [W2-1:0]  s2r;
    logic [OUT_WIDTH-1:0]  q;
    logic                  full;
    logic                  empty;
    logic                  wr_ok;
    logic                  overflow;
    logic [CW-1:0]         wr_ch;
    logic [CW+OUT_WIDTH-1:0] head;

    always_ff @(posedge i_clk) begin
        v1    <= i_rst ? 1'b0 : i_accum_valid;
        sum1  <= {i_accum_data[DATA_WIDTH-1], i_accum_data} + {i_param_cfg_bias[DATA_WIDTH-1], i_param_cfg_bias};
        sh1   <= i_param_cfg_shift;
        relu1 <= i_relu_en;
    end

    always_comb begin
        rnd = W2'(round_term(sh1));
        s2  = ($signed({sum1[DATA_WIDTH], sum1}) + rnd) >>> sh1;
        s2r = (relu1 && s2[W2-1]) ? '0 : s2;
        q   = OUT_WIDTH'(saturate(64'(s2r), OUT_WIDTH));
    end

    // a full FIFO still takes the write when the consumer pops the head this cycle
    assign wr_ok = v1 && (!full || i_ready);

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            wr_ch    <= '0;
            overflow <= 1'b0;
        end else begin
            if (wr_ok) wr_ch <= (wr_ch == CW'(N_CHANNEL - 1)) ? '0 : wr_ch + 1'b1;
            if (v1 && !wr_ok) overflow <= 1'b1;
        end
    end

    sync_fifo #(
        .WIDTH (CW + OUT_WIDTH),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .i_clk   (i_clk),
        .i_rst   (i_rst),
        .i_wr    (wr_ok),
        .i_wdata ({wr_ch, q}),
        .i_rd    (i_ready),
        .o_rdata (head),
        .o_full  (full),
        .o_empty (empty)
    );

    assign o_valid    = !empty;
    assign o_data     = empty ? '0 : head[OUT_WIDTH-1:0];
    assign o_out_ch   = empty ? '0 : head[CW+OUT_WIDTH-1:OUT_WIDTH];
    assign o_last     = !empty && (head[CW+OUT_WIDTH-1:OUT_WIDTH] == CW'(N_CHANNEL - 1));
    assign o_overflow = overflow;

endmodule
